// File: rtl/coherence_pkg.sv
// MSI coherence types and helpers shared by the dcache and its snoop responder.
// Holds the snoop FSM state type, MSI encoding helpers and address field slices.
package coherence_pkg;

  localparam int DC_TAG_W = 26;
  localparam int DC_IDX_W = 3;

  typedef enum logic [1:0] {IDLE, LOOKUP, XFER0, XFER1} snoop_state_t;

  typedef enum logic [1:0] {MSI_I = 2'd0, MSI_S = 2'd1, MSI_M = 2'd2} msi_t;

  // The tag array stores MSI as (valid, dirty); dirty implies Modified.
  function automatic msi_t msi_of(input logic valid, input logic dirty);
    if (!valid) return MSI_I;
    return dirty ? MSI_M : MSI_S;
  endfunction

  // Line state after a remote snoop: an invalidate always wins, otherwise M downgrades to S.
  function automatic msi_t snoop_next(input msi_t cur, input logic inv);
    if (inv) return MSI_I;
    if (cur == MSI_M) return MSI_S;
    return cur;
  endfunction

  function automatic logic [DC_TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: DC_TAG_W];
  endfunction

  function automatic logic [DC_IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[3 +: DC_IDX_W];
  endfunction

  function automatic logic addr_word(input logic [31:0] a);
    return a[2];
  endfunction

  function automatic logic [28:0] addr_blk(input logic [31:0] a);
    return a[31:3];
  endfunction

endpackage

// File: rtl/snoop_tag_match.sv
// Parallel tag compare across all ways of one set; purely combinational.
// Reports hit, the dirty bit of the hit line, and the hit way.
module snoop_tag_match #(
  parameter int TAG_W = 26,
  parameter int WAYS  = 2,
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] tags,
  input  logic [WAYS-1:0]       valid,
  input  logic [WAYS-1:0]       dirty,
  output logic                  hit,
  output logic                  hit_dirty,
  output logic [WAY_W-1:0]      hit_way
);

  // Walk from the highest way down so the lowest matching way is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_dirty = 1'b0;
    hit_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w] && (tags[w*TAG_W +: TAG_W] == tag)) begin
        hit       = 1'b1;
        hit_dirty = dirty[w];
        hit_way   = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Dcache-side MSI snoop responder: tag lookup, Modified-line writeback sourcing,
// M->S downgrade / invalidate of the local tag array, and link register clearing.
module dcache_snoop_responder
  import coherence_pkg::*;
#(
  parameter int TAG_W = DC_TAG_W,
  parameter int IDX_W = DC_IDX_W,
  parameter int WAYS  = 2,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ccwait,
  input  logic                  ccinv,
  input  logic [31:0]           ccsnoopaddr,
  input  logic                  dwait,
  output logic                  cctrans,
  output logic [31:0]           snoop_dstore,
  output logic                  snoop_active,
  output logic [IDX_W-1:0]      snp_idx,
  input  logic [WAYS*TAG_W-1:0] snp_tag,
  input  logic [WAYS-1:0]       snp_valid,
  input  logic [WAYS-1:0]       snp_dirty,
  input  logic [WAYS*64-1:0]    snp_data,
  output logic                  upd_en,
  output logic [WAY_W-1:0]      upd_way,
  output logic [IDX_W-1:0]      upd_idx,
  output logic                  upd_valid,
  output logic                  upd_dirty,
  input  logic [31:0]           lr_addr,
  input  logic                  lr_valid,
  output logic                  lr_clear
);

  snoop_state_t     state, state_next;
  logic             inv_lat;
  logic [WAY_W-1:0] way_lat;
  logic [IDX_W-1:0] idx_lat;

  logic             hit, hit_dirty;
  logic [WAY_W-1:0] hit_way;
  msi_t             hit_state;
  logic             lr_match;
  logic [31:0]      word_sel;
  logic             unused_bits;

  assign snp_idx     = ccsnoopaddr[3 +: IDX_W];
  assign hit_state   = msi_of(hit, hit_dirty);
  assign lr_match    = lr_valid && (addr_blk(lr_addr) == addr_blk(ccsnoopaddr));
  assign unused_bits = ^{lr_addr[2:0], ccsnoopaddr[1:0]};

  snoop_tag_match #(
    .TAG_W (TAG_W),
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_match (
    .tag       (ccsnoopaddr[31 -: TAG_W]),
    .tags      (snp_tag),
    .valid     (snp_valid),
    .dirty     (snp_dirty),
    .hit       (hit),
    .hit_dirty (hit_dirty),
    .hit_way   (hit_way)
  );

  // The requester steps its address per word, so the word is picked live from ccsnoopaddr[2].
  always_comb begin
    word_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < 2; k++) begin
        if ((WAY_W'(w) == way_lat) && (1'(k) == addr_word(ccsnoopaddr)))
          word_sel = snp_data[(w*2+k)*32 +: 32];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      inv_lat <= 1'b0;
      way_lat <= '0;
      idx_lat <= '0;
    end else begin
      state <= state_next;
      if (state == LOOKUP) begin
        inv_lat <= ccinv;
        way_lat <= hit_way;
        idx_lat <= snp_idx;
      end
    end
  end

  always_comb begin
    state_next   = state;
    snoop_active = 1'b0;
    cctrans      = 1'b0;
    snoop_dstore = '0;
    upd_en       = 1'b0;
    upd_way      = '0;
    upd_idx      = '0;
    upd_valid    = 1'b0;
    upd_dirty    = 1'b0;
    lr_clear     = 1'b0;
    case (state)
      IDLE: begin
        if (ccwait) begin
          snoop_active = 1'b1;
          state_next   = LOOKUP;
        end
      end
      LOOKUP: begin
        snoop_active = 1'b1;
        cctrans      = (hit_state == MSI_M);
        if (hit_state == MSI_M) begin
          state_next = XFER0;
        end else begin
          state_next = IDLE;
          // A clean line can be invalidated right away; nothing has to be written back.
          if (hit_state == MSI_S && ccinv) begin
            upd_en    = 1'b1;
            upd_way   = hit_way;
            upd_idx   = snp_idx;
            upd_valid = 1'b0;
            lr_clear  = lr_match;
          end
        end
      end
      XFER0: begin
        snoop_active = 1'b1;
        cctrans      = 1'b1;
        snoop_dstore = word_sel;
        if (!dwait) state_next = XFER1;
      end
      XFER1: begin
        snoop_active = 1'b1;
        cctrans      = 1'b1;
        snoop_dstore = word_sel;
        if (!dwait) begin
          upd_en     = 1'b1;
          upd_way    = way_lat;
          upd_idx    = idx_lat;
          upd_valid  = (snoop_next(MSI_M, inv_lat) != MSI_I);
          lr_clear   = inv_lat && lr_match;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new request while busy is a controller protocol error; the FSM ignores it.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      assert (!(ccwait && state != IDLE))
      else $warning("snoop request while busy ignored");
    end
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Self-checking bench: the bench owns the tag/data array and predicts every
// response from the MSI snoop rules (lookup, downgrade/invalidate, link clear).
module tb_dcache_snoop_responder;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         ccwait, ccinv, dwait;
  logic [31:0]  ccsnoopaddr;
  logic         cctrans, snoop_active;
  logic [31:0]  snoop_dstore;
  logic [2:0]   snp_idx;
  logic [51:0]  snp_tag;
  logic [1:0]   snp_valid, snp_dirty;
  logic [127:0] snp_data;
  logic         upd_en, upd_valid, upd_dirty;
  logic [0:0]   upd_way;
  logic [2:0]   upd_idx;
  logic [31:0]  lr_addr;
  logic         lr_valid, lr_clear;

  logic [25:0]  mtag  [8][2];
  bit           mvalid[8][2];
  bit           mdirty[8][2];
  logic [31:0]  mdata [8][2][2];

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  dcache_snoop_responder dut (
    .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dwait(dwait), .cctrans(cctrans), .snoop_dstore(snoop_dstore), .snoop_active(snoop_active),
    .snp_idx(snp_idx), .snp_tag(snp_tag), .snp_valid(snp_valid), .snp_dirty(snp_dirty),
    .snp_data(snp_data), .upd_en(upd_en), .upd_way(upd_way), .upd_idx(upd_idx),
    .upd_valid(upd_valid), .upd_dirty(upd_dirty), .lr_addr(lr_addr), .lr_valid(lr_valid),
    .lr_clear(lr_clear)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present the set selected by the address, as the dcache arrays would.
  task automatic set_addr(input logic [31:0] a);
    int i;
    i = int'(a[5:3]);
    ccsnoopaddr = a;
    for (int w = 0; w < 2; w++) begin
      snp_tag[w*26 +: 26] = mtag[i][w];
      snp_valid[w]        = mvalid[i][w];
      snp_dirty[w]        = mdirty[i][w];
      for (int k = 0; k < 2; k++) snp_data[(w*2+k)*32 +: 32] = mdata[i][w][k];
    end
  endtask

  task automatic fill(input int i, input int w, input int tag, input bit v, input bit d);
    mtag[i][w] = 26'(tag);
    mvalid[i][w] = v;
    mdirty[i][w] = d;
    mdata[i][w][0] = $urandom;
    mdata[i][w][1] = $urandom;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_active"}, snoop_active, 0);
    chk({tag, "_trans"}, cctrans, 0);
    chk({tag, "_upd"}, {upd_en, upd_way, upd_idx, upd_valid, upd_dirty}, 0);
    chk({tag, "_lrclr"}, lr_clear, 0);
    chk({tag, "_dstore"}, snoop_dstore, 0);
  endtask

  task automatic do_snoop(input logic [31:0] a, input bit inv, input int d0, input int d1,
                          input bit ccw_x1, input bit rst_x0);
    int  idx, way;
    bit  hit, dirty, lrm, wsel;
    idx = int'(a[5:3]);
    hit = 0; way = 0; dirty = 0;
    for (int w = 0; w < 2; w++) begin
      if (!hit && mvalid[idx][w] && mtag[idx][w] == a[31:6]) begin
        hit = 1; way = w; dirty = mdirty[idx][w];
      end
    end
    lrm = lr_valid && (lr_addr[31:3] == a[31:3]);

    ccwait = 1; ccinv = 1'($urandom); dwait = 1; set_addr(a);
    #3;
    chk("req_active", snoop_active, 1);
    chk("req_trans", cctrans, 0);
    chk("req_upd", upd_en, 0);
    tick();

    ccwait = 0; ccinv = inv; set_addr(a);
    #3;
    chk("lk_idx", snp_idx, idx);
    chk("lk_active", snoop_active, 1);
    chk("lk_trans", cctrans, hit && dirty);
    chk("lk_upd", upd_en, hit && !dirty && inv);
    if (hit && !dirty && inv) begin
      chk("lk_upd_way", upd_way, way);
      chk("lk_upd_idx", upd_idx, idx);
      chk("lk_upd_vd", {upd_valid, upd_dirty}, 0);
      chk("lk_lrclr", lr_clear, lrm);
    end else begin
      chk("lk_lrclr", lr_clear, 0);
    end
    tick();
    if (!(hit && dirty)) begin
      if (hit && inv) mvalid[idx][way] = 0;
      #3;
      check_idle("end_short");
      tick();
      return;
    end

    for (int c = 0; c <= d0; c++) begin
      wsel = (c == d0) ? 1'b0 : 1'($urandom);
      ccinv = 1'($urandom);
      dwait = (c != d0);
      set_addr({a[31:3], wsel, 2'b00});
      if (rst_x0) begin
        nRST = 0; dwait = 1;
        #3;
        chk("rst_noupd", upd_en, 0);
        tick();
        #3;
        check_idle("rst");
        nRST = 1;
        tick();
        return;
      end
      #3;
      chk("x0_trans", {cctrans, snoop_active}, 2'b11);
      chk("x0_dstore", snoop_dstore, mdata[idx][way][wsel]);
      chk("x0_upd", upd_en, 0);
      tick();
    end

    for (int c = 0; c <= d1; c++) begin
      wsel = (c == d1) ? 1'b1 : 1'($urandom);
      ccinv = 1'($urandom);
      ccwait = ccw_x1 && (c == 0);
      dwait = (c != d1);
      set_addr({a[31:3], wsel, 2'b00});
      #3;
      chk("x1_trans", {cctrans, snoop_active}, 2'b11);
      chk("x1_dstore", snoop_dstore, mdata[idx][way][wsel]);
      chk("x1_upd", upd_en, c == d1);
      if (c == d1) begin
        chk("x1_upd_way", upd_way, way);
        chk("x1_upd_idx", upd_idx, idx);
        chk("x1_upd_vd", {upd_valid, upd_dirty}, {!inv, 1'b0});
        chk("x1_lrclr", lr_clear, inv && lrm);
      end else begin
        chk("x1_lrclr", lr_clear, 0);
      end
      tick();
    end
    ccwait = 0;
    mdirty[idx][way] = 0;
    if (inv) mvalid[idx][way] = 0;
    #3;
    check_idle("end_xfer");
    tick();
  endtask

  initial begin
    int t, i;
    nRST = 0; ccwait = 0; ccinv = 0; dwait = 1; lr_valid = 0; lr_addr = 0;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) fill(s, w, 0, 0, 0);
    set_addr(32'h0);
    tick(); tick();
    #3;
    check_idle("reset");
    nRST = 1;
    tick();

    // Miss: nothing with tag 1 in set 0.
    do_snoop(32'h0000_0040, 0, 0, 0, 0, 0);

    // Shared line in set 0 way 1, invalidated.
    fill(0, 0, 9, 1, 0);
    fill(0, 1, 5, 1, 0);
    do_snoop(32'h0000_0140, 1, 0, 0, 0, 0);

    // Modified line, downgrade with slow handshakes.
    fill(2, 0, 16, 1, 1);
    mdata[2][0][0] = 32'hDEAD_BEEF;
    mdata[2][0][1] = 32'hCAFE_F00D;
    do_snoop(32'h0000_0410, 0, 3, 2, 0, 0);

    // Modified line invalidated while linked.
    fill(6, 1, 32'h48, 1, 1);
    lr_valid = 1; lr_addr = 32'h0000_1234;
    do_snoop(32'h0000_1230, 1, 1, 1, 0, 0);
    lr_valid = 0;

    // Reset during the transfer leaves the line untouched, so it is still Modified afterwards.
    fill(4, 0, 7, 1, 1);
    do_snoop(32'h0000_01E0, 0, 2, 0, 0, 1);
    do_snoop(32'h0000_01E4, 0, 0, 1, 1, 0);

    // Both ways carrying the same tag: way 0 is the one that answers.
    fill(3, 0, 12, 1, 0);
    fill(3, 1, 12, 1, 1);
    do_snoop(32'h0000_0318, 1, 0, 0, 0, 0);
    fill(3, 1, 13, 1, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(2) == 0) begin
        i = $urandom_range(7);
        if ($urandom_range(1) == 0) fill(i, 0, $urandom_range(2), 1, 1'($urandom));
        else fill(i, 1, 3 + $urandom_range(2), 1, 1'($urandom));
      end
      i = $urandom_range(7);
      t = $urandom_range(6);
      lr_valid = 1'($urandom);
      lr_addr = ($urandom_range(1) == 0) ? {26'(t), 3'(i), 3'($urandom)} : $urandom;
      do_snoop({26'(t), 3'(i), 1'($urandom), 2'b00}, 1'($urandom), $urandom_range(3),
               $urandom_range(3), ($urandom_range(3) == 0), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
